// File: rtl/fetch_pc_unit.sv
`default_nettype none
//============================================================================
// Module   : fetch_pc_unit
// Brief    : Instruction fetch / PC stage feeding controlUnit; defining
//            FETCH_TRAP_EN enables the invalid-instruction / misaligned-jr trap.
// Revision : 1.0 - initial release
//============================================================================
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        instr_valid,
   output logic        retire,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        branch_eq,
   input  logic        branch_neq,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic        invalid_inst,
   input  logic        alu_zero,
   input  logic [31:0] rs_data,
   input  logic        stall,
   output logic        trap,
   output logic [31:0] epc,
   output logic [31:0] instret
);

`ifdef FETCH_TRAP_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_TRAP  = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_e;
`endif

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        imem_req_q;
   logic        instr_valid_q;
   logic [31:0] instret_q;
   logic [31:0] npc_d;
   logic [31:0] branch_off;
   logic [31:0] jr_target;
   logic        branch_taken;
   logic        trap_cond;

`ifdef FETCH_TRAP_EN
   logic        trap_q;
   logic [31:0] epc_q;
`else
   logic        unused_cfg;
   assign unused_cfg = ^{invalid_inst, rs_data[1:0], TRAP_VECTOR};
`endif

   assign pc_plus4     = pc_q + 32'd4;
   assign branch_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign branch_taken = (branch_eq & alu_zero) | (branch_neq & ~alu_zero);

`ifdef FETCH_TRAP_EN
   assign trap_cond = invalid_inst | (jump_reg & (|rs_data[1:0]));
   assign jr_target = rs_data;
`else
   assign trap_cond = 1'b0;
   // Without traps a misaligned jr target is silently word-aligned.
   assign jr_target = {rs_data[31:2], 2'b00};
`endif

   always_comb begin
      npc_d = pc_plus4;
      if (jump_reg) begin
         npc_d = jr_target;
      end else if (jump) begin
         npc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (branch_taken) begin
         npc_d = pc_plus4 + branch_off;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 32'd0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         instret_q     <= 32'd0;
`ifdef FETCH_TRAP_EN
         trap_q        <= 1'b0;
         epc_q         <= 32'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q    <= S_FETCH;
               imem_req_q <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  instr_q       <= imem_rdata;
                  imem_req_q    <= 1'b0;
                  instr_valid_q <= 1'b1;
                  state_q       <= S_EXEC;
               end
            end
            S_EXEC: begin
               // Control inputs are only consumed on the edge that leaves EXEC.
               if (!stall) begin
                  instr_valid_q <= 1'b0;
                  if (trap_cond) begin
`ifdef FETCH_TRAP_EN
                     trap_q  <= 1'b1;
                     state_q <= S_TRAP;
`endif
                  end else begin
                     pc_q       <= npc_d;
                     instret_q  <= instret_q + 32'd1;
                     imem_req_q <= 1'b1;
                     state_q    <= S_FETCH;
                  end
               end
            end
`ifdef FETCH_TRAP_EN
            S_TRAP: begin
               trap_q     <= 1'b0;
               epc_q      <= pc_q;
               pc_q       <= TRAP_VECTOR;
               imem_req_q <= 1'b1;
               state_q    <= S_FETCH;
            end
`endif
            default: begin
               state_q       <= S_IDLE;
               imem_req_q    <= 1'b0;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign instr_valid = instr_valid_q;
   assign retire      = instr_valid_q & ~stall & ~trap_cond;
   assign pc          = pc_q;
   assign instret     = instret_q;

`ifdef FETCH_TRAP_EN
   assign trap = trap_q;
   assign epc  = epc_q;
`else
   assign trap = 1'b0;
   assign epc  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Self-checking bench for fetch_pc_unit (both FETCH_TRAP_EN builds).
// Revision : 1.0 - initial release
//============================================================================
module tb_fetch_pc_unit;

`ifdef FETCH_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        instr_valid;
   logic        retire;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        branch_eq, branch_neq, jump, jump_reg, invalid_inst, alu_zero;
   logic [31:0] rs_data;
   logic        stall;
   logic        trap;
   logic [31:0] epc;
   logic [31:0] instret;

   int          n_checks;
   int          n_fail;
   logic [31:0] m_pc;
   logic [31:0] m_instret;
   logic [31:0] m_epc;

   fetch_pc_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .funct(funct),
      .instr_valid(instr_valid), .retire(retire),
      .pc(pc), .pc_plus4(pc_plus4),
      .branch_eq(branch_eq), .branch_neq(branch_neq), .jump(jump),
      .jump_reg(jump_reg), .invalid_inst(invalid_inst),
      .alu_zero(alu_zero), .rs_data(rs_data), .stall(stall),
      .trap(trap), .epc(epc), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: instruction-level semantics, no notion of RTL states.
   function automatic logic model_traps(logic inv, logic jr, logic [31:0] rsd);
      return TRAP_EN && (inv || (jr && (rsd % 4 != 0)));
   endfunction

   function automatic logic [31:0] model_npc(logic [31:0] p, logic [31:0] w,
         logic beq, logic bne, logic j, logic jr, logic inv, logic zero,
         logic [31:0] rsd);
      logic [31:0] sx;
      if (model_traps(inv, jr, rsd)) return 32'h0000_0080;
      if (jr) return TRAP_EN ? rsd : rsd - (rsd % 4);
      if (j) return ((p + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
      sx = {{16{w[15]}}, w[15:0]};
      if ((beq && zero) || (bne && !zero)) return p + 32'd4 + sx * 32'd4;
      return p + 32'd4;
   endfunction

   task automatic clear_ctrl();
      branch_eq = 0; branch_neq = 0; jump = 0; jump_reg = 0;
      invalid_inst = 0; alu_zero = 0; rs_data = 32'd0; stall = 0;
   endtask

   // Plays memory and control unit for one instruction; starts and ends at a
   // negedge with the DUT requesting a fetch. Returns what it observed.
   task automatic exec_one(input logic [31:0] word, input int lat, input int stl,
         input logic beq, input logic bne, input logic j, input logic jr,
         input logic inv, input logic zero, input logic [31:0] rsd,
         output int cyc, output int req_bad, output int valid_bad,
         output int retires, output int traps,
         output logic [5:0] opc, output logic [5:0] fun, output logic [31:0] ir);
      logic [31:0] a0;
      cyc = 0; req_bad = 0; valid_bad = 0; retires = 0; traps = 0;
      a0 = imem_addr;
      for (int i = 0; i < lat; i++) begin
         imem_ready = 1'b0; imem_rdata = $urandom; #1;
         if (imem_req !== 1'b1 || imem_addr !== a0 || instr_valid !== 1'b0) req_bad++;
         @(negedge clk); cyc++;
      end
      imem_ready = 1'b1; imem_rdata = word; #1;
      if (imem_req !== 1'b1 || imem_addr !== a0) req_bad++;
      @(negedge clk); cyc++;
      imem_rdata = ~word;
      opc = opcode; fun = funct; ir = instr;
      branch_eq = beq; branch_neq = bne; jump = j; jump_reg = jr;
      invalid_inst = inv; alu_zero = zero; rs_data = rsd;
      for (int i = 0; i <= stl; i++) begin
         stall = (i < stl); #1;
         if (instr_valid !== 1'b1 || imem_req !== 1'b0) valid_bad++;
         if (retire === 1'b1) retires++;
         if (trap === 1'b1) traps++;
         @(negedge clk); cyc++;
      end
      clear_ctrl();
      imem_ready = 1'b0;
      while (imem_req !== 1'b1 && cyc < 50) begin
         #1;
         if (trap === 1'b1) traps++;
         if (retire === 1'b1) retires++;
         @(negedge clk); cyc++;
      end
   endtask

   task automatic goto_pc(input logic [31:0] tgt);
      int c, rb, vb, rt, tp;
      logic [5:0] o, f;
      logic [31:0] ir;
      exec_one(32'h0000_0008, 0, 0, 0, 0, 0, 1, 0, 0, tgt, c, rb, vb, rt, tp, o, f, ir);
      m_pc = tgt; m_instret++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; clear_ctrl();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 00000000", pc); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
      n_checks++; if ({imem_req, instr_valid, retire, trap} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags got req/valid/retire/trap=%b want 0000",
                             {imem_req, instr_valid, retire, trap}); end
      n_checks++; if (epc !== 32'h0 || instret !== 32'h0) begin
         n_fail++; $display("FAIL reset_counters got epc=%h instret=%0d want 0/0", epc, instret); end
      rst_n = 1'b1; #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b want 0", imem_req); end
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL first_fetch got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
      m_pc = 32'h0; m_instret = 32'h0; m_epc = 32'h0;
   endtask

   task automatic test_nop_stream();
      int c, rb, vb, rt, tp, total;
      logic [5:0] o, f;
      logic [31:0] ir;
      total = 0;
      for (int k = 0; k < 10; k++) begin
         n_checks++; if (imem_addr !== 32'(k * 4)) begin
            n_fail++; $display("FAIL nop_addr[%0d] got %h want %h", k, imem_addr, 32'(k * 4)); end
         exec_one(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, c, rb, vb, rt, tp, o, f, ir);
         total += c;
         n_checks++; if (rt !== 1 || c !== 2) begin
            n_fail++; $display("FAIL nop_retire[%0d] got retires=%0d cycles=%0d want 1/2", k, rt, c); end
         m_pc += 4; m_instret++;
      end
      n_checks++; if (total !== 20 || instret !== 32'd10) begin
         n_fail++; $display("FAIL nop_instret got cycles=%0d instret=%0d want 20/10", total, instret); end
      n_checks++; if (pc !== 32'd40) begin n_fail++; $display("FAIL nop_pc got %h want 00000028", pc); end
   endtask

   task automatic test_branch();
      logic       t_beq [6] = '{1, 1, 0, 0, 1, 1};
      logic       t_bne [6] = '{0, 0, 1, 1, 1, 1};
      logic       t_zero[6] = '{1, 0, 0, 1, 0, 1};
      logic [31:0] t_exp[6] = '{32'h04, 32'h14, 32'h04, 32'h14, 32'h04, 32'h04};
      int c, rb, vb, rt, tp;
      logic [5:0] o, f;
      logic [31:0] ir;
      for (int k = 0; k < 6; k++) begin
         goto_pc(32'h10);
         exec_one(32'h1000_FFFC, 0, 0, t_beq[k], t_bne[k], 0, 0, 0, t_zero[k], 32'h0,
                  c, rb, vb, rt, tp, o, f, ir);
         m_pc = t_exp[k]; m_instret++;
         n_checks++; if (pc !== t_exp[k]) begin
            n_fail++; $display("FAIL branch[%0d] pc got %h want %h", k, pc, t_exp[k]); end
         n_checks++; if (o !== 6'h04 || f !== 6'h3C || ir !== 32'h1000_FFFC) begin
            n_fail++; $display("FAIL branch_decode[%0d] got op=%h fn=%h ir=%h want 04/3c/1000fffc", k, o, f, ir); end
      end
   endtask

   task automatic test_jump();
      int c, rb, vb, rt, tp;
      logic [5:0] o, f;
      logic [31:0] ir;
      goto_pc(32'h2000_0000);
      exec_one(32'h0800_0040, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, c, rb, vb, rt, tp, o, f, ir);
      m_pc = 32'h2000_0100; m_instret++;
      n_checks++; if (pc !== 32'h2000_0100) begin n_fail++; $display("FAIL jump_pc got %h want 20000100", pc); end
      exec_one(32'h0000_0008, 0, 0, 0, 0, 0, 1, 0, 0, 32'h400, c, rb, vb, rt, tp, o, f, ir);
      m_pc = 32'h400; m_instret++;
      n_checks++; if (pc !== 32'h400) begin n_fail++; $display("FAIL jr_pc got %h want 00000400", pc); end
      exec_one(32'h0800_0040, 0, 0, 1, 0, 1, 1, 0, 1, 32'h1234_5678, c, rb, vb, rt, tp, o, f, ir);
      m_pc = 32'h1234_5678; m_instret++;
      n_checks++; if (pc !== 32'h1234_5678) begin n_fail++; $display("FAIL jr_priority got %h want 12345678", pc); end
      goto_pc(32'hFFFF_FFFC);
      exec_one(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, c, rb, vb, rt, tp, o, f, ir);
      m_pc = 32'h0; m_instret++;
      n_checks++; if (pc !== 32'h0 || instret !== m_instret) begin
         n_fail++; $display("FAIL pc_wrap got pc=%h instret=%0d want 0/%0d", pc, instret, m_instret); end
   endtask

   task automatic test_latency_stall();
      int c, rb, vb, rt, tp;
      logic [5:0] o, f;
      logic [31:0] ir;
      logic [31:0] p0;
      p0 = m_pc;
      exec_one(32'h0000_0020, 3, 2, 0, 0, 0, 0, 0, 0, 32'h0, c, rb, vb, rt, tp, o, f, ir);
      m_pc = p0 + 32'd4; m_instret++;
      n_checks++; if (c !== 7) begin n_fail++; $display("FAIL lat_cycles got %0d want 7", c); end
      n_checks++; if (rt !== 1) begin n_fail++; $display("FAIL lat_retires got %0d want 1", rt); end
      n_checks++; if (rb !== 0 || vb !== 0) begin
         n_fail++; $display("FAIL lat_hold got addr_errs=%0d valid_errs=%0d want 0/0", rb, vb); end
      n_checks++; if (pc !== m_pc || instret !== m_instret) begin
         n_fail++; $display("FAIL lat_state got pc=%h instret=%0d want %h/%0d", pc, instret, m_pc, m_instret); end
   endtask

   task automatic test_trap();
      int c, rb, vb, rt, tp;
      logic [5:0] o, f;
      logic [31:0] ir;
      logic [31:0] i0;
      goto_pc(32'h30);
      i0 = m_instret;
      exec_one(32'hFC00_003F, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, c, rb, vb, rt, tp, o, f, ir);
      m_pc = TRAP_EN ? 32'h80 : 32'h34;
      m_epc = TRAP_EN ? 32'h30 : 32'h0;
      m_instret = i0 + (TRAP_EN ? 32'd0 : 32'd1);
      n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL trap_pc got %h want %h", pc, m_pc); end
      n_checks++; if (epc !== m_epc) begin n_fail++; $display("FAIL trap_epc got %h want %h", epc, m_epc); end
      n_checks++; if (tp !== (TRAP_EN ? 1 : 0) || rt !== (TRAP_EN ? 0 : 1)) begin
         n_fail++; $display("FAIL trap_pulse got trap_cycles=%0d retires=%0d want %0d/%0d",
                            tp, rt, TRAP_EN ? 1 : 0, TRAP_EN ? 0 : 1); end
      n_checks++; if (instret !== m_instret || c !== (TRAP_EN ? 3 : 2)) begin
         n_fail++; $display("FAIL trap_count got instret=%0d cycles=%0d want %0d/%0d",
                            instret, c, m_instret, TRAP_EN ? 3 : 2); end
      goto_pc(32'h50);
      exec_one(32'h0000_0008, 0, 0, 0, 0, 0, 1, 0, 0, 32'h403, c, rb, vb, rt, tp, o, f, ir);
      m_pc = TRAP_EN ? 32'h80 : 32'h400;
      m_epc = TRAP_EN ? 32'h50 : 32'h0;
      if (!TRAP_EN) m_instret++;
      n_checks++; if (pc !== m_pc || epc !== m_epc) begin
         n_fail++; $display("FAIL jr_misaligned got pc=%h epc=%h want %h/%h", pc, epc, m_pc, m_epc); end
   endtask

   task automatic test_reset_mid_fetch();
      goto_pc(32'h100);
      imem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b0 || pc !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid_req got req=%b pc=%h want 0/00000000", imem_req, pc); end
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid_refetch got instr=%h req=%b addr=%h want 0/1/00000000",
                            instr, imem_req, imem_addr); end
      imem_ready = 1'b0;
      m_pc = 32'h0; m_instret = 32'h0; m_epc = 32'h0;
   endtask

   task automatic test_random();
      int c, rb, vb, rt, tp, lat, stl, errs;
      logic [5:0] o, f;
      logic [31:0] ir, w, rsd, exp_pc;
      logic beq, bne, j, jr, inv, zero, tk;
      errs = 0;
      for (int k = 0; k < 60; k++) begin
         w = $urandom; rsd = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) rsd = rsd | 32'($urandom_range(1, 3));
         beq = ($urandom_range(0, 2) == 0); bne = ($urandom_range(0, 2) == 0);
         j = ($urandom_range(0, 4) == 0); jr = ($urandom_range(0, 4) == 0);
         inv = ($urandom_range(0, 7) == 0); zero = $urandom_range(0, 1) == 1;
         lat = $urandom_range(0, 3); stl = $urandom_range(0, 2);
         n_checks++; if (imem_addr !== m_pc) begin
            n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", k, imem_addr, m_pc); end
         exec_one(w, lat, stl, beq, bne, j, jr, inv, zero, rsd, c, rb, vb, rt, tp, o, f, ir);
         tk = model_traps(inv, jr, rsd);
         exp_pc = model_npc(m_pc, w, beq, bne, j, jr, inv, zero, rsd);
         if (tk) m_epc = m_pc; else m_instret++;
         m_pc = exp_pc;
         n_checks++; if (pc !== m_pc || instret !== m_instret || epc !== m_epc) begin
            n_fail++; $display("FAIL rnd_state[%0d] got pc=%h instret=%0d epc=%h want %h/%0d/%h",
                               k, pc, instret, epc, m_pc, m_instret, m_epc); end
         n_checks++; if (c !== lat + stl + 2 + (tk ? 1 : 0) || rt !== (tk ? 0 : 1) || tp !== (tk ? 1 : 0)) begin
            n_fail++; $display("FAIL rnd_timing[%0d] got cycles=%0d retires=%0d traps=%0d want %0d/%0d/%0d",
                               k, c, rt, tp, lat + stl + 2 + (tk ? 1 : 0), tk ? 0 : 1, tk ? 1 : 0); end
         n_checks++; if (o !== w[31:26] || f !== w[5:0] || ir !== w || rb !== 0 || vb !== 0) begin
            n_fail++; $display("FAIL rnd_fetch[%0d] got op=%h fn=%h ir=%h errs=%0d/%0d want %h/%h/%h/0/0",
                               k, o, f, ir, rb, vb, w[31:26], w[5:0], w); end
         errs += rb + vb;
      end
      n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL rnd_handshake got %0d errors want 0", errs); end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      m_pc = 32'h0; m_instret = 32'h0; m_epc = 32'h0;
      rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
      clear_ctrl();
      test_reset();
      test_nop_stream();
      test_branch();
      test_jump();
      test_latency_stall();
      test_trap();
      test_reset_mid_fetch();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
